// File: rtl/uart_im_loader.sv
// Serial instruction-memory loader: 8N1 receiver plus a packet parser that writes
// little-endian words to IM and releases the CPU once the image checksum matches.
module uart_im_loader #(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ADDR_W = 10,
  parameter logic [7:0]  SYNC   = 8'hA5
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RxD,
  output logic              imWe,
  output logic [ADDR_W-1:0] imAddr,
  output logic [31:0]       imData,
  output logic              cpuHold,
  output logic              loadDone,
  output logic              loadError
);

  localparam int unsigned DIVISOR   = CLK_HZ / BAUD;
  localparam int unsigned HALF      = DIVISOR / 2;
  localparam int unsigned CNT_W     = $clog2(DIVISOR + 1);
  localparam int unsigned N_W       = ADDR_W + 1;
  localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_CNT0, P_CNT1, P_DATA, P_CSUM, P_DONE, P_ERROR} p_state_t;

  // Receiver registers
  logic             r_rx_meta, r_rx_sync, r_rx_prev;
  rx_state_t        r_rx_state, w_rx_state_nxt;
  logic [CNT_W-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]       r_rx_bit, w_rx_bit_nxt;
  logic [7:0]       r_rx_shift, w_rx_shift_nxt;
  logic             r_rx_strobe, w_rx_strobe_nxt;
  logic             r_frame_err, w_frame_err_nxt;

  // Parser registers
  p_state_t          r_p_state, w_p_state_nxt;
  logic [7:0]        r_cnt_lo, w_cnt_lo_nxt;
  logic [N_W-1:0]    r_n, w_n_nxt;
  logic [N_W-1:0]    r_word_idx, w_word_idx_nxt;
  logic [1:0]        r_byte_idx, w_byte_idx_nxt;
  logic [23:0]       r_word, w_word_nxt;
  logic [7:0]        r_csum, w_csum_nxt;
  logic              r_im_we, w_im_we_nxt;
  logic [ADDR_W-1:0] r_im_addr, w_im_addr_nxt;
  logic [31:0]       r_im_data, w_im_data_nxt;
  logic              r_cpu_hold, w_cpu_hold_nxt;
  logic              r_load_done, w_load_done_nxt;
  logic              r_load_error, w_load_error_nxt;

  logic [15:0]       w_n_raw;
  logic [N_W-1:0]    w_written;

  assign imWe      = r_im_we;
  assign imAddr    = r_im_addr;
  assign imData    = r_im_data;
  assign cpuHold   = r_cpu_hold;
  assign loadDone  = r_load_done;
  assign loadError = r_load_error;

  // Synchronizer, edge history and receiver state
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rx_meta   <= 1'b1;
      r_rx_sync   <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_state  <= RX_IDLE;
      r_rx_cnt    <= '0;
      r_rx_bit    <= '0;
      r_rx_shift  <= '0;
      r_rx_strobe <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= RxD;
      r_rx_sync   <= r_rx_meta;
      r_rx_prev   <= r_rx_sync;
      r_rx_state  <= w_rx_state_nxt;
      r_rx_cnt    <= w_rx_cnt_nxt;
      r_rx_bit    <= w_rx_bit_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_rx_strobe <= w_rx_strobe_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  // Receiver next state: mid-bit sampling, start re-check rejects glitches
  always_comb begin
    w_rx_state_nxt  = r_rx_state;
    w_rx_cnt_nxt    = r_rx_cnt + CNT_W'(1);
    w_rx_bit_nxt    = r_rx_bit;
    w_rx_shift_nxt  = r_rx_shift;
    w_rx_strobe_nxt = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (r_rx_prev && !r_rx_sync) w_rx_state_nxt = RX_START;
      end
      RX_START: begin
        if (r_rx_cnt == CNT_W'(HALF - 1)) begin
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == CNT_W'(DIVISOR - 1)) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          w_rx_bit_nxt   = r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) w_rx_state_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == CNT_W'(DIVISOR - 1)) begin
          w_rx_cnt_nxt    = '0;
          w_rx_state_nxt  = RX_IDLE;
          w_rx_strobe_nxt = r_rx_sync;
          w_frame_err_nxt = !r_rx_sync;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  // Parser state and IM write port
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_p_state    <= P_IDLE;
      r_cnt_lo     <= '0;
      r_n          <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
      r_word       <= '0;
      r_csum       <= '0;
      r_im_we      <= 1'b0;
      r_im_addr    <= '0;
      r_im_data    <= '0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_p_state    <= w_p_state_nxt;
      r_cnt_lo     <= w_cnt_lo_nxt;
      r_n          <= w_n_nxt;
      r_word_idx   <= w_word_idx_nxt;
      r_byte_idx   <= w_byte_idx_nxt;
      r_word       <= w_word_nxt;
      r_csum       <= w_csum_nxt;
      r_im_we      <= w_im_we_nxt;
      r_im_addr    <= w_im_addr_nxt;
      r_im_data    <= w_im_data_nxt;
      r_cpu_hold   <= w_cpu_hold_nxt;
      r_load_done  <= w_load_done_nxt;
      r_load_error <= w_load_error_nxt;
    end
  end

  assign w_n_raw   = {r_rx_shift, r_cnt_lo};
  assign w_written = r_word_idx + N_W'(1);

  // Parser next state; a framing error mid-packet aborts to ERROR
  always_comb begin
    w_p_state_nxt    = r_p_state;
    w_cnt_lo_nxt     = r_cnt_lo;
    w_n_nxt          = r_n;
    w_word_idx_nxt   = r_word_idx;
    w_byte_idx_nxt   = r_byte_idx;
    w_word_nxt       = r_word;
    w_csum_nxt       = r_csum;
    w_im_we_nxt      = 1'b0;
    w_im_addr_nxt    = r_im_addr;
    w_im_data_nxt    = r_im_data;
    w_cpu_hold_nxt   = r_cpu_hold;
    w_load_done_nxt  = r_load_done;
    w_load_error_nxt = r_load_error;
    case (r_p_state)
      P_IDLE, P_ERROR: begin
        if (r_rx_strobe && r_rx_shift == SYNC) begin
          w_p_state_nxt    = P_CNT0;
          w_load_error_nxt = 1'b0;
          w_csum_nxt       = '0;
          w_im_addr_nxt    = '0;
        end
      end
      P_CNT0: begin
        if (r_rx_strobe) begin
          w_cnt_lo_nxt  = r_rx_shift;
          w_p_state_nxt = P_CNT1;
        end
      end
      P_CNT1: begin
        if (r_rx_strobe) begin
          if (w_n_raw == 16'd0 || 32'(w_n_raw) > MAX_WORDS) begin
            w_p_state_nxt    = P_ERROR;
            w_load_error_nxt = 1'b1;
          end else begin
            w_n_nxt        = N_W'(w_n_raw);
            w_word_idx_nxt = '0;
            w_byte_idx_nxt = '0;
            w_p_state_nxt  = P_DATA;
          end
        end
      end
      P_DATA: begin
        if (r_im_we) begin
          w_im_addr_nxt  = r_im_addr + ADDR_W'(1);
          w_word_idx_nxt = w_written;
          if (w_written == r_n) w_p_state_nxt = P_CSUM;
        end
        if (r_rx_strobe) begin
          w_csum_nxt     = r_csum ^ r_rx_shift;
          w_byte_idx_nxt = r_byte_idx + 2'd1;
          case (r_byte_idx)
            2'd0: w_word_nxt[7:0]   = r_rx_shift;
            2'd1: w_word_nxt[15:8]  = r_rx_shift;
            2'd2: w_word_nxt[23:16] = r_rx_shift;
            default: begin
              w_im_data_nxt = {r_rx_shift, r_word};
              w_im_we_nxt   = 1'b1;
            end
          endcase
        end
      end
      P_CSUM: begin
        if (r_rx_strobe) begin
          if (r_rx_shift == r_csum) begin
            w_p_state_nxt   = P_DONE;
            w_load_done_nxt = 1'b1;
            w_cpu_hold_nxt  = 1'b0;
          end else begin
            w_p_state_nxt    = P_ERROR;
            w_load_error_nxt = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (r_frame_err && (r_p_state == P_CNT0 || r_p_state == P_CNT1 ||
                        r_p_state == P_DATA || r_p_state == P_CSUM)) begin
      w_p_state_nxt    = P_ERROR;
      w_load_error_nxt = 1'b1;
      w_im_we_nxt      = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_im_loader.sv
// Directed bench for uart_im_loader: serial packets in, IM writes scoreboarded
// against words queued as they are sent.
module tb_uart_im_loader;

  localparam int unsigned AW  = 5;
  localparam int unsigned DIV = 16;
  localparam int unsigned MAXW = 2 ** AW;

  logic          Clock = 1'b0;
  logic          Reset;
  logic          RxD;
  logic          imWe;
  logic [AW-1:0] imAddr;
  logic [31:0]   imData;
  logic          cpuHold;
  logic          loadDone;
  logic          loadError;

  uart_im_loader #(.CLK_HZ(160), .BAUD(10), .ADDR_W(AW), .SYNC(8'hA5)) dut (
    .Clock(Clock), .Reset(Reset), .RxD(RxD), .imWe(imWe), .imAddr(imAddr),
    .imData(imData), .cpuHold(cpuHold), .loadDone(loadDone), .loadError(loadError)
  );

  always #5 Clock = ~Clock;

  logic [63:0] obs_q[$];
  logic [63:0] exp_q[$];
  int rd_ptr  = 0;
  int n_pass  = 0;
  int n_total = 0;

  // Every cycle with imWe high is one observed write
  always @(negedge Clock)
    if (imWe === 1'b1) obs_q.push_back({32'(imAddr), imData});

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
  endtask

  task automatic settle();
    repeat (2) @(negedge Clock);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop = 1'b1);
    RxD = 1'b0;
    repeat (DIV) @(negedge Clock);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (DIV) @(negedge Clock);
    end
    RxD = stop;
    repeat (DIV) @(negedge Clock);
    RxD = 1'b1;
    if (!stop) repeat (DIV) @(negedge Clock);
  endtask

  task automatic send_load(input logic [31:0] words[$], input bit bad, input bit expect_wr);
    logic [7:0] cs;
    logic [7:0] b;
    logic [15:0] n;
    cs = 8'h00;
    n  = 16'(words.size());
    send_byte(8'hA5);
    settle();
    chk("err_clear_at_sync", 64'(loadError), 64'd0);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < words.size(); i++) begin
      for (int k = 0; k < 4; k++) begin
        b  = words[i][8*k +: 8];
        cs = cs ^ b;
        send_byte(b);
      end
      if (expect_wr) exp_q.push_back({32'(i), words[i]});
    end
    send_byte(cs ^ {7'd0, bad});
    settle();
  endtask

  task automatic check_writes(input string tag);
    logic [63:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_ptr < obs_q.size()) begin
        chk({tag, "_write"}, obs_q[rd_ptr], e);
        rd_ptr++;
      end else begin
        chk({tag, "_missing_write"}, 64'hFFFF_FFFF_FFFF_FFFF, e);
      end
    end
    chk({tag, "_write_count"}, 64'(obs_q.size()), 64'(rd_ptr));
    rd_ptr = obs_q.size();
  endtask

  task automatic check_flags(input string tag, input bit hold, input bit done, input bit err);
    chk({tag, "_cpuHold"},   64'(cpuHold),   64'(hold));
    chk({tag, "_loadDone"},  64'(loadDone),  64'(done));
    chk({tag, "_loadError"}, 64'(loadError), 64'(err));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_imWe"},   64'(imWe),   64'd0);
    chk({tag, "_imAddr"}, 64'(imAddr), 64'd0);
    chk({tag, "_imData"}, 64'(imData), 64'd0);
    check_flags(tag, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin
    logic [31:0] wq[$];
    logic [31:0] big[$];
    RxD   = 1'b1;
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    check_reset_vals("reset");
    Reset = 1'b0;
    repeat (4) @(negedge Clock);

    // Basic two-word load
    wq.push_back(32'h12345678);
    wq.push_back(32'hDEADBEEF);
    send_load(wq, 1'b0, 1'b1);
    check_writes("basic");
    check_flags("basic_done", 1'b0, 1'b1, 1'b0);

    // Traffic after DONE is ignored
    big.delete();
    big.push_back(32'hCAFEF00D);
    send_load(big, 1'b0, 1'b0);
    check_writes("post_done");
    check_flags("post_done", 1'b0, 1'b1, 1'b0);

    // Bad checksum, then recovery by a good packet
    do_reset();
    send_load(wq, 1'b1, 1'b1);
    check_writes("bad_csum");
    check_flags("bad_csum", 1'b1, 1'b0, 1'b1);
    send_load(wq, 1'b0, 1'b1);
    check_writes("reload");
    check_flags("reload", 1'b0, 1'b1, 1'b0);

    // Count bounds
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    settle();
    check_flags("n_zero", 1'b1, 1'b0, 1'b1);
    send_byte(8'hA5);
    settle();
    chk("n_1025_sync_clr", 64'(loadError), 64'd0);
    send_byte(8'h01); send_byte(8'h04);
    settle();
    chk("n_1025_err", 64'(loadError), 64'd1);
    send_byte(8'hA5); send_byte(8'(MAXW + 1)); send_byte(8'h00);
    settle();
    chk("n_max_plus1_err", 64'(loadError), 64'd1);
    check_writes("bounds_err");
    big.delete();
    for (int i = 0; i < int'(MAXW); i++) big.push_back($urandom);
    send_load(big, 1'b0, 1'b1);
    check_writes("full");
    check_flags("full", 1'b0, 1'b1, 1'b0);
    chk("full_addr_wrap", 64'(imAddr), 64'd0);

    // Glitch and framing error in IDLE must not start a packet
    do_reset();
    RxD = 1'b0;
    repeat (3) @(negedge Clock);
    RxD = 1'b1;
    repeat (40) @(negedge Clock);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00); send_byte(8'h00);
    settle();
    check_flags("idle_noise", 1'b1, 1'b0, 1'b0);
    // Framing error during DATA
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33, 1'b0); send_byte(8'h44);
    settle();
    check_flags("frame_err", 1'b1, 1'b0, 1'b1);
    check_writes("frame_err");

    // Reset mid-packet after five payload bytes
    do_reset();
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    exp_q.push_back({32'd0, 32'h44332211});
    send_byte(8'h55);
    check_writes("mid_pkt");
    Reset = 1'b1;
    @(negedge Clock);
    check_reset_vals("mid_reset");
    Reset = 1'b0;
    repeat (4) @(negedge Clock);
    wq.delete();
    wq.push_back(32'hA1B2C3D4);
    wq.push_back(32'h0F1E2D3C);
    send_load(wq, 1'b0, 1'b1);
    check_writes("after_reset");
    check_flags("after_reset", 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
